// File: rtl/aftab_csr_sequencer.sv
// AFTAB CSR update sequencer: Zicsr read-modify-write, trap entry and xRET as chains of single-CSR writes.
// Define AFTAB_USER_MODE_EN for user-level traps, uret and ustatus/uie/uip mirroring onto machine CSRs.
module aftab_csr_sequencer #(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           startCSRop,
  input  logic           startTrap,
  input  logic           startRet,
  input  logic [2:0]     funct3,
  input  logic [11:0]    csrAddrIn,
  input  logic [4:0]     ir19_15,
  input  logic [len-1:0] P1,
  input  logic [len-1:0] PC,
  input  logic [len-1:0] causeCode,
  input  logic [len-1:0] trapValue,
  input  logic           trapToUser,
  input  logic           retLevel,
  input  logic [1:0]     curPRV,
  input  logic [len-1:0] outCSR,
  output logic [11:0]    csrAddr,
  output logic [len-1:0] inCSR,
  output logic           writeCSR,
  output logic [len-1:0] rdData,
  output logic [1:0]     newPRV,
  output logic           busy,
  output logic           done,
  output logic           illegal
);

  typedef enum logic [2:0] {
    IDLE, CSR_RD, CSR_WR, T_EPC, T_CAUSE, T_TVAL, T_STATUS, R_STATUS
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, prv_q;
  logic           imm_q, user_q, uret_q;
  logic [11:0]    addr_q;
  logic [4:0]     uimm_q;
  logic [len-1:0] p1_q, pc_q, cause_q, tval_q, old_q, rd_q;

  logic trap_user;
`ifdef AFTAB_USER_MODE_EN
  assign trap_user = trapToUser;
`else
  logic unused_trap_to_user;
  assign trap_user           = 1'b0;
  assign unused_trap_to_user = trapToUser;
`endif

  // User views are redirected to the machine CSR; mask selects the bits the view may touch.
  logic [11:0]    eff_addr;
  logic [len-1:0] mask;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eff_addr = addr_q;
    mask     = '1;
`ifdef AFTAB_USER_MODE_EN
    case (addr_q)
      12'h000: begin eff_addr = 12'h300; mask = len'(12'h011); end
      12'h004: begin eff_addr = 12'h304; mask = len'(12'h111); end
      12'h044: begin eff_addr = 12'h344; mask = len'(12'h111); end
      default: ;
    endcase
`endif
  end

  logic [len-1:0] src, new_val, wr_val;
  logic           write_pending, csr_illegal, ret_illegal;
  always_comb begin
    src = imm_q ? len'(uimm_q) : p1_q;
    case (op_q)
      2'b01:   new_val = src;
      2'b10:   new_val = old_q | src;
      2'b11:   new_val = old_q & ~src;
      default: new_val = old_q;
    endcase
    wr_val        = (old_q & ~mask) | (new_val & mask);
    write_pending = (op_q == 2'b01) || (uimm_q != 5'd0);
    csr_illegal   = (addr_q[9:8] > prv_q) || (op_q == 2'b00) ||
                    (write_pending && (addr_q[11:10] == 2'b11));
`ifdef AFTAB_USER_MODE_EN
    ret_illegal   = !uret_q && (prv_q != 2'b11);
`else
    csr_illegal   = csr_illegal || (addr_q[9:8] == 2'b00);
    ret_illegal   = uret_q || (prv_q != 2'b11);
`endif
  end

  // Status rewrites read the live CSR value in the same cycle they write it back.
  logic [len-1:0] trap_status, ret_status;
  logic [1:0]     ret_prv;
  always_comb begin
    trap_status = outCSR;
    ret_status  = outCSR;
    ret_prv     = 2'b00;
    if (user_q) begin
      trap_status[4] = outCSR[0];
      trap_status[0] = 1'b0;
    end else begin
      trap_status[12:11] = prv_q;
      trap_status[7]     = outCSR[3];
      trap_status[3]     = 1'b0;
    end
    if (uret_q) begin
      ret_status[0] = outCSR[4];
      ret_status[4] = 1'b1;
    end else begin
      ret_status[3] = outCSR[7];
      ret_status[7] = 1'b1;
`ifdef AFTAB_USER_MODE_EN
      ret_status[12:11] = 2'b00;
`else
      ret_status[12:11] = 2'b11;
`endif
      ret_prv = outCSR[12:11];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (startTrap)       state_d = T_EPC;
        else if (startRet)   state_d = R_STATUS;
        else if (startCSRop) state_d = CSR_RD;
      end
      CSR_RD:   state_d = csr_illegal ? IDLE : CSR_WR;
      T_EPC:    state_d = T_CAUSE;
      T_CAUSE:  state_d = T_TVAL;
      T_TVAL:   state_d = T_STATUS;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    csrAddr  = 12'h000;
    inCSR    = '0;
    writeCSR = 1'b0;
    newPRV   = 2'b00;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      CSR_RD: begin
        csrAddr = eff_addr;
        illegal = csr_illegal;
      end
      CSR_WR: begin
        csrAddr  = eff_addr;
        inCSR    = wr_val;
        writeCSR = write_pending;
        done     = 1'b1;
      end
      T_EPC:   begin csrAddr = user_q ? 12'h041 : 12'h341; inCSR = pc_q;    writeCSR = 1'b1; end
      T_CAUSE: begin csrAddr = user_q ? 12'h042 : 12'h342; inCSR = cause_q; writeCSR = 1'b1; end
      T_TVAL:  begin csrAddr = user_q ? 12'h043 : 12'h343; inCSR = tval_q;  writeCSR = 1'b1; end
      T_STATUS: begin
        csrAddr  = user_q ? 12'h000 : 12'h300;
        inCSR    = trap_status;
        writeCSR = 1'b1;
        done     = 1'b1;
        newPRV   = user_q ? 2'b00 : 2'b11;
      end
      R_STATUS: begin
        csrAddr = uret_q ? 12'h000 : 12'h300;
        if (ret_illegal) begin
          illegal = 1'b1;
        end else begin
          inCSR    = ret_status;
          writeCSR = 1'b1;
          done     = 1'b1;
          newPRV   = uret_q ? 2'b00 : ret_prv;
        end
      end
      default: ;
    endcase
  end

  // NOTE: operand registers are not reset; they are always reloaded at start before anything reads them.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      op_q    <= funct3[1:0];
      imm_q   <= funct3[2];
      addr_q  <= csrAddrIn;
      uimm_q  <= ir19_15;
      p1_q    <= P1;
      pc_q    <= PC;
      cause_q <= causeCode;
      tval_q  <= trapValue;
      user_q  <= trap_user;
      uret_q  <= retLevel;
      prv_q   <= curPRV;
    end
    if (state_q == CSR_RD) old_q <= outCSR;
  end

  always_ff @(posedge clk) begin
    if (rst)                    rd_q <= '0;
    else if (state_q == CSR_RD) rd_q <= outCSR & mask;
  end

  assign rdData = rd_q;

endmodule

// File: tb/tb_aftab_csr_sequencer.sv
// Scoreboard bench for aftab_csr_sequencer: directed requests queue the expected CSR-file events
// (write / done / illegal with their cycle), and an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_aftab_csr_sequencer;
  localparam int LEN = 32;

  logic            clk = 1'b0;
  logic            rst, startCSRop, startTrap, startRet, trapToUser, retLevel;
  logic [2:0]      funct3;
  logic [11:0]     csrAddrIn, csrAddr;
  logic [4:0]      ir19_15;
  logic [LEN-1:0]  P1, PC, causeCode, trapValue, outCSR, inCSR, rdData;
  logic [1:0]      curPRV, newPRV;
  logic            writeCSR, busy, done, illegal;

  always #5 clk = ~clk;

  aftab_csr_sequencer #(.len(LEN)) dut (
    .clk(clk), .rst(rst), .startCSRop(startCSRop), .startTrap(startTrap), .startRet(startRet),
    .funct3(funct3), .csrAddrIn(csrAddrIn), .ir19_15(ir19_15), .P1(P1), .PC(PC),
    .causeCode(causeCode), .trapValue(trapValue), .trapToUser(trapToUser), .retLevel(retLevel),
    .curPRV(curPRV), .outCSR(outCSR), .csrAddr(csrAddr), .inCSR(inCSR), .writeCSR(writeCSR),
    .rdData(rdData), .newPRV(newPRV), .busy(busy), .done(done), .illegal(illegal)
  );

  // Behavioural CSR file: combinational read, write on the clock edge, plus a preload port.
  logic [31:0] csr_mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h000;
  logic [31:0] pl_data = 32'h0;
  assign outCSR = csr_mem[csrAddr];
  always @(posedge clk) begin
    if (writeCSR) csr_mem[csrAddr] <= inCSR;
    if (pl_en)    csr_mem[pl_addr] <= pl_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_NONE, EV_WR, EV_DONE, EV_ILL} ev_e;
  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
    bit          chk_rd;
    bit          chk_prv;
    logic [1:0]  prv;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_wr(int c, logic [11:0] a, logic [31:0] d);
    exp_t e;
    e = '{EV_WR, c, a, d, 1'b0, 1'b0, 2'b00};
    sb.push_back(e);
  endtask

  task automatic exp_done(int c, bit chk_rd, logic [31:0] rd, bit chk_prv, logic [1:0] prv);
    exp_t e;
    e = '{EV_DONE, c, 12'h000, rd, chk_rd, chk_prv, prv};
    sb.push_back(e);
  endtask

  task automatic exp_ill(int c);
    exp_t e;
    e = '{EV_ILL, c, 12'h000, 32'h0, 1'b0, 1'b0, 2'b00};
    sb.push_back(e);
  endtask

  task automatic observe(ev_e k);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_event_kind", 64'(k), 64'(EV_NONE));
      return;
    end
    e = sb.pop_front();
    check("event_kind", 64'(k), 64'(e.kind));
    check("event_cycle", 64'(cyc), 64'(e.cyc));
    case (e.kind)
      EV_WR: begin
        check("write_addr", 64'(csrAddr), 64'(e.addr));
        check("write_data", 64'(inCSR), 64'(e.data));
      end
      EV_DONE: begin
        if (e.chk_rd)  check("rdData", 64'(rdData), 64'(e.data));
        if (e.chk_prv) check("newPRV", 64'(newPRV), 64'(e.prv));
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(negedge clk);
    if (writeCSR === 1'b1) observe(EV_WR);
    if (done === 1'b1)     observe(EV_DONE);
    if (illegal === 1'b1)  observe(EV_ILL);
  end

  task automatic preload(logic [11:0] a, logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic set_csr(logic [2:0] f3, logic [11:0] a, logic [4:0] rs1, logic [31:0] p1, logic [1:0] prv);
    funct3 = f3; csrAddrIn = a; ir19_15 = rs1; P1 = p1; curPRV = prv;
  endtask

  task automatic set_trap(logic [31:0] pc, logic [31:0] cause, logic [31:0] tval, logic [1:0] prv, logic to_user);
    PC = pc; causeCode = cause; trapValue = tval; curPRV = prv; trapToUser = to_user;
  endtask

  // Raises the selected starts for one cycle; n is the start cycle.
  task automatic pulse(bit t, bit r, bit c, output int n);
    @(posedge clk); #1;
    startTrap = t; startRet = r; startCSRop = c;
    n = cyc;
    @(posedge clk); #1;
    startTrap = 1'b0; startRet = 1'b0; startCSRop = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int n, n2;
    logic [31:0] mret_status;
    rst = 1'b1; startCSRop = 1'b0; startTrap = 1'b0; startRet = 1'b0;
    trapToUser = 1'b0; retLevel = 1'b0;
    set_csr(3'b000, 12'h000, 5'd0, 32'h0, 2'b00);
    set_trap(32'h0, 32'h0, 32'h0, 2'b00, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);
    check("reset_writeCSR", 64'(writeCSR), 64'd0);
    check("reset_csrAddr", 64'(csrAddr), 64'd0);
    check("reset_inCSR", 64'(inCSR), 64'd0);
    check("reset_rdData", 64'(rdData), 64'd0);
    check("reset_newPRV", 64'(newPRV), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // CSRRS mstatus |= 0x8
    preload(12'h300, 32'h0000_1800);
    set_csr(3'b010, 12'h300, 5'd1, 32'h8, 2'b11);
    pulse(0, 0, 1, n);
    exp_wr(n + 2, 12'h300, 32'h0000_1808);
    exp_done(n + 2, 1, 32'h0000_1800, 0, 2'b00);
    drain();

    // CSRRCI with uimm = 0: read only, no write
    preload(12'h341, 32'h0000_1234);
    set_csr(3'b111, 12'h341, 5'd0, 32'hFFFF_FFFF, 2'b11);
    pulse(0, 0, 1, n);
    exp_done(n + 2, 1, 32'h0000_1234, 0, 2'b00);
    drain();

    // CSRRWI, then back-to-back CSRRS / CSRRC on mscratch
    preload(12'h340, 32'h0000_AAAA);
    set_csr(3'b101, 12'h340, 5'd5, 32'hFFFF_FFFF, 2'b11);
    pulse(0, 0, 1, n);
    exp_wr(n + 2, 12'h340, 32'h0000_0005);
    exp_done(n + 2, 1, 32'h0000_AAAA, 0, 2'b00);
    drain();
    set_csr(3'b010, 12'h340, 5'd3, 32'h30, 2'b11);
    pulse(0, 0, 1, n);
    exp_wr(n + 2, 12'h340, 32'h0000_0035);
    exp_done(n + 2, 1, 32'h0000_0005, 0, 2'b00);
    set_csr(3'b011, 12'h340, 5'd4, 32'h1, 2'b11);
    @(posedge clk);
    pulse(0, 0, 1, n2);
    exp_wr(n2 + 2, 12'h340, 32'h0000_0034);
    exp_done(n2 + 2, 1, 32'h0000_0035, 0, 2'b00);
    drain();

    // CSRRC mie &= ~0xF
    preload(12'h304, 32'h0000_0F0F);
    set_csr(3'b011, 12'h304, 5'd2, 32'hF, 2'b11);
    pulse(0, 0, 1, n);
    exp_wr(n + 2, 12'h304, 32'h0000_0F00);
    exp_done(n + 2, 1, 32'h0000_0F0F, 0, 2'b00);
    drain();

    // Machine CSR accessed from S level, then a write to read-only mhartid
    set_csr(3'b010, 12'h300, 5'd1, 32'h8, 2'b01);
    pulse(0, 0, 1, n);
    exp_ill(n + 1);
    drain();
    set_csr(3'b001, 12'hF11, 5'd1, 32'h1, 2'b11);
    pulse(0, 0, 1, n);
    exp_ill(n + 1);
    drain();

    // Trap from U level
    preload(12'h300, 32'h0000_0008);
    set_trap(32'h100, 32'h8000_000B, 32'h0, 2'b00, 1'b0);
    pulse(1, 0, 0, n);
    exp_wr(n + 1, 12'h341, 32'h0000_0100);
    exp_wr(n + 2, 12'h342, 32'h8000_000B);
    exp_wr(n + 3, 12'h343, 32'h0000_0000);
    exp_wr(n + 4, 12'h300, 32'h0000_0080);
    exp_done(n + 4, 0, 32'h0, 1, 2'b11);
    drain();

    // Trap beats a simultaneous CSR op; a CSR start mid-trap is ignored
    preload(12'h300, 32'h0000_0009);
    set_trap(32'h200, 32'h5, 32'hDEAD_BEEF, 2'b01, 1'b0);
    set_csr(3'b001, 12'h340, 5'd1, 32'h77, 2'b01);
    pulse(1, 0, 1, n);
    exp_wr(n + 1, 12'h341, 32'h0000_0200);
    exp_wr(n + 2, 12'h342, 32'h0000_0005);
    exp_wr(n + 3, 12'h343, 32'hDEAD_BEEF);
    exp_wr(n + 4, 12'h300, 32'h0000_0881);
    exp_done(n + 4, 0, 32'h0, 1, 2'b11);
    @(posedge clk); #1 startCSRop = 1'b1;
    @(posedge clk); #1 startCSRop = 1'b0;
    drain();

    // mret from M level, then the same request from U level
`ifdef AFTAB_USER_MODE_EN
    mret_status = 32'h0000_0088;
`else
    mret_status = 32'h0000_1888;
`endif
    preload(12'h300, 32'h0000_1880);
    retLevel = 1'b0; curPRV = 2'b11;
    pulse(0, 1, 0, n);
    exp_wr(n + 1, 12'h300, mret_status);
    exp_done(n + 1, 0, 32'h0, 1, 2'b11);
    drain();
    preload(12'h300, 32'h0000_1880);
    curPRV = 2'b00;
    pulse(0, 1, 0, n);
    exp_ill(n + 1);
    drain();

    // Reset during T_CAUSE aborts the rest of the trap
    preload(12'h300, 32'h0000_0008);
    set_trap(32'h300, 32'h7, 32'h11, 2'b11, 1'b0);
    pulse(1, 0, 0, n);
    exp_wr(n + 1, 12'h341, 32'h0000_0300);
    exp_wr(n + 2, 12'h342, 32'h0000_0007);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("busy_after_abort", 64'(busy), 64'd0);
    drain();

    // User-level views and uret
    preload(12'h300, 32'h0000_1800);
    set_csr(3'b001, 12'h000, 5'd1, 32'h0000_FFFF, 2'b11);
    pulse(0, 0, 1, n);
`ifdef AFTAB_USER_MODE_EN
    exp_wr(n + 2, 12'h300, 32'h0000_1811);
    exp_done(n + 2, 1, 32'h0000_0000, 0, 2'b00);
`else
    exp_ill(n + 1);
`endif
    drain();

    preload(12'h000, 32'h0000_0010);
    retLevel = 1'b1; curPRV = 2'b00;
    pulse(0, 1, 0, n);
`ifdef AFTAB_USER_MODE_EN
    exp_wr(n + 1, 12'h000, 32'h0000_0011);
    exp_done(n + 1, 0, 32'h0, 1, 2'b00);
`else
    exp_ill(n + 1);
`endif
    drain();
    retLevel = 1'b0;

`ifdef AFTAB_USER_MODE_EN
    preload(12'h304, 32'h0000_0901);
    set_csr(3'b010, 12'h004, 5'd6, 32'hFFFF_FFFF, 2'b00);
    pulse(0, 0, 1, n);
    exp_wr(n + 2, 12'h304, 32'h0000_0911);
    exp_done(n + 2, 1, 32'h0000_0101, 0, 2'b00);
    drain();

    preload(12'h000, 32'h0000_0001);
    set_trap(32'h400, 32'h8, 32'h22, 2'b00, 1'b1);
    pulse(1, 0, 0, n);
    exp_wr(n + 1, 12'h041, 32'h0000_0400);
    exp_wr(n + 2, 12'h042, 32'h0000_0008);
    exp_wr(n + 3, 12'h043, 32'h0000_0022);
    exp_wr(n + 4, 12'h000, 32'h0000_0010);
    exp_done(n + 4, 0, 32'h0, 1, 2'b00);
    drain();
    trapToUser = 1'b0;
`endif

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aftab_csr_sequencer.md
# aftab_csr_sequencer

Multi-cycle CSR update sequencer for the AFTAB interrupt datapath. It sits between the controller and the CSR register file. It executes Zicsr read-modify-write instructions, trap entry and xRET sequences as FSM-driven chains of single-CSR writes. Write width is parametrised, privilege checking is built in, and user-level CSR views are optionally mirrored onto machine CSRs.

## Interface
- len, 32, CSR/data width; must be ≥ 32; bits above 31 pass through status updates unchanged
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- startCSRop  in  1  one-cycle request: Zicsr instruction
- startTrap  in  1  one-cycle request: trap entry
- startRet  in  1  one-cycle request: xRET
- funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csrAddrIn  in  12  target CSR address
- ir19_15  in  5  rs1 field / uimm, zero-extended to len
- P1  in  len  rs1 value
- PC, causeCode, trapValue  in  len each  values for xepc / xcause / xtval
- trapToUser  in  1  trap delegated to U level (macro only, else ignored)
- retLevel  in  1  0 = mret, 1 = uret
- curPRV  in  2  current privilege
- outCSR  in  len  CSR file read data, combinational on csrAddr
- csrAddr  out  12  CSR file address
- inCSR  out  len  CSR file write data
- writeCSR  out  1  CSR file write enable
- rdData  out  len  old CSR value for rd
- newPRV  out  2  privilege after trap/ret, valid with done
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle illegal-instruction pulse

## Operation
- States: IDLE, CSR_RD, CSR_WR, T_EPC, T_CAUSE, T_TVAL, T_STATUS, R_STATUS.
- IDLE start priority: startTrap > startRet > startCSRop. Starts are ignored while busy. Operands are latched at start.
- CSR op:
  - CSR_RD: csrAddr = addr; outCSR is captured into rdData.
  - Illegal if addr[9:8] > curPRV, or if a write is pending and addr[11:10] = 11. On illegal: pulse illegal, no write, no done, go to IDLE.
  - CSR_WR computes the new value: RW → src; RS → old | src; RC → old & ~src. src = P1 or uimm.
  - RS/RC/RSI/RCI with ir19_15 = 0: writeCSR stays 0. done pulses.
- Trap, M level:
  - T_EPC writes 0x341 ← PC. T_CAUSE writes 0x342 ← causeCode. T_TVAL writes 0x343 ← trapValue.
  - T_STATUS writes 0x300 with MPP[12:11] ← curPRV, MPIE[7] ← MIE[3], MIE ← 0. newPRV = 11. done pulses.
- mret:
  - Illegal if curPRV ≠ 11.
  - R_STATUS: MIE ← MPIE, MPIE ← 1, MPP ← 00. newPRV = old MPP. done pulses.
- Unlisted status bits are written back unchanged.

## Timing
- Reset: state IDLE; all outputs 0; rdData 0. Reset mid-sequence aborts immediately, with no further write and no done; CSRs already written stay written.
- CSR op: start cycle N; CSR_RD N+1; CSR_WR and done N+2. Illegal pulses at N+1.
- Trap: writes at N+1..N+4; done at N+4.
- Ret: R_STATUS and done at N+1 (illegal at N+1 if privilege fails).
- A new start is accepted in the cycle after done/illegal.
- writeCSR is only ever high for one cycle per state; inCSR is valid whenever writeCSR = 1.

## Configuration
- AFTAB_USER_MODE_EN defined:
  - User trap handling:
    - trapToUser = 1 targets 0x041, 0x042, 0x043, 0x000.
    - Status update: UPIE[4] ← UIE[0], UIE ← 0. newPRV = 00.
  - uret: UIE ← UPIE, UPIE ← 1, newPRV = 00. Illegal if curPRV = 11 is not required.
  - Mirroring:
    - CSR ops on 0x000 are redirected to 0x300 with write = (old & ~0x11) | (new & 0x11); rdData = old & 0x11.
    - 0x004 / 0x044 are redirected to 0x304 / 0x344 with mask 0x111.
  - mret sets MPP ← 00.
- Macro undefined:
  - trapToUser is ignored.
  - uret and any CSR address with addr[9:8] = 00 raise illegal.
  - mret sets MPP ← 11.
  - No mirror logic.

## Test plan
- CSRRS 0x300 with P1 = 0x8, old = 0x1800, curPRV = 11 → write 0x1808 at N+2, rdData = 0x1800, done at N+2.
- CSRRCI with uimm = 0 on 0x341 → writeCSR never high, done at N+2, rdData = old value.
- Trap with PC = 0x100, cause = 0x8000000B, tval = 0, status 0x8, curPRV = 00 → writes 0x341 = 0x100, 0x342 = 0x8000000B, 0x343 = 0, 0x300 = 0x80; newPRV = 11; done at N+4.
- mret with status 0x1880, curPRV = 11 → 0x300 ← 0x88, newPRV = 11, done at N+1. Same request with curPRV = 00 → illegal at N+1, no write.
- CSRRW to 0xF11 (read-only) → illegal at N+1, no write. rst asserted at T_CAUSE → no T_TVAL/T_STATUS write, busy = 0 next cycle.
- With AFTAB_USER_MODE_EN: CSRRW 0x000 ← 0xFFFF, mstatus = 0x1800 → 0x300 ← 0x1811. Without the macro, the same instruction → illegal.
